// File: rtl/team_06_pkg.sv
// -----------------------------------------------------------------------------
// team_06_pkg
// Shared definitions for the clip arbiter slice: the arbiter FSM state type
// and the soft-clip knee/ceiling constants used by the clip stage.
// No ports (package).
// -----------------------------------------------------------------------------
package team_06_pkg;

  // Arbiter FSM: wait for a request, run the clip stage, hold the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Samples at or below the knee pass untouched; the ceiling bounds the output
  localparam logic [7:0] CLIP_START = 8'd180;
  localparam logic [7:0] CLIP_MAX   = 8'd220;

endpackage

// File: rtl/team_06_soft_clipping.sv
// -----------------------------------------------------------------------------
// team_06_soft_clipping
// Purely combinational soft clipper shared by both requesters.
//   x_i : unsigned 8-bit input sample
//   y_o : clipped sample
// Transfer: x <= knee -> x; knee < x <= ceiling -> knee + half the excess;
// above the ceiling -> ceiling. Every intermediate value fits in 8 bits.
// -----------------------------------------------------------------------------
module team_06_soft_clipping
  import team_06_pkg::*;
(
  input  logic [7:0] x_i,
  output logic [7:0] y_o
);

  logic [7:0] excess;

  // Halving the excess over the knee gives the soft region its gentler slope
  always_comb begin
    excess = x_i - CLIP_START;
    if (x_i <= CLIP_START) begin
      y_o = x_i;
    end else if (x_i <= CLIP_MAX) begin
      y_o = CLIP_START + (excess >> 1);
    end else begin
      y_o = CLIP_MAX;
    end
  end

endmodule

// File: rtl/team_06_clip_arbiter.sv
// -----------------------------------------------------------------------------
// team_06_clip_arbiter
// Round-robin arbiter feeding two 8-bit requesters through one shared soft
// clipper, with a saturating count of clipped samples.
//   clk, rst      : clock and synchronous active-high reset
//   req_valid[1:0]: per-requester sample valid
//   req_data0/1   : per-requester unsigned sample
//   req_ready[1:0]: per-requester accept strobe (one-hot, IDLE only)
//   clip_en       : route through the clipper (1) or bypass (0)
//   out_valid/out_data/out_id : registered result and requester index
//   out_ready     : downstream accept
//   clip_count    : saturating count of clipped samples above the knee
// -----------------------------------------------------------------------------
module team_06_clip_arbiter
  import team_06_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [7:0]       req_data0,
  input  logic [7:0]       req_data1,
  output logic [1:0]       req_ready,
  input  logic             clip_en,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] clip_count
);

  state_e           state_q;
  logic             lastGrant_q;
  logic [7:0]       sample_q;
  logic             gid_q;
  logic             clipEn_q;
  logic             outValid_q;
  logic [7:0]       outData_q;
  logic             outId_q;
  logic [CNT_W-1:0] clipCount_q;

  logic             grant;
  logic             transfer;
  logic [7:0]       clipped;

  // Round-robin pick: a lone requester always wins; on a tie the requester
  // that was not served last goes next. The pointer resets to 1 so
  // requester 0 wins the first tie after reset.
  always_comb begin
    if (req_valid == 2'b11) begin
      grant = ~lastGrant_q;
    end else begin
      grant = req_valid[1];
    end
  end

  // Ready is only offered while idle and never during reset, so a sample
  // cannot sneak in on the reset edge
  always_comb begin
    req_ready = 2'b00;
    if (!rst && (state_q == IDLE) && (req_valid != 2'b00)) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

  assign transfer = |(req_valid & req_ready);

  team_06_soft_clipping u_clip (
    .x_i (sample_q),
    .y_o (clipped)
  );

  // Single FSM: latch the granted sample, compute the result one cycle later,
  // then hold it until downstream accepts. clip_en is captured with the
  // sample so later changes do not disturb the in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      sample_q    <= 8'd0;
      gid_q       <= 1'b0;
      clipEn_q    <= 1'b0;
      outValid_q  <= 1'b0;
      outData_q   <= 8'd0;
      outId_q     <= 1'b0;
      clipCount_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (transfer) begin
            sample_q <= grant ? req_data1 : req_data0;
            gid_q    <= grant;
            clipEn_q <= clip_en;
            state_q  <= PROC;
          end
        end
        PROC: begin
          outData_q  <= clipEn_q ? clipped : sample_q;
          outId_q    <= gid_q;
          outValid_q <= 1'b1;
          if (clipEn_q && (sample_q > CLIP_START) && (clipCount_q != '1)) begin
            clipCount_q <= clipCount_q + CNT_W'(1);
          end
          state_q <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            outValid_q  <= 1'b0;
            lastGrant_q <= gid_q;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign out_id     = outId_q;
  assign clip_count = clipCount_q;

endmodule

// File: tb/tb_team_06_clip_arbiter.sv
// -----------------------------------------------------------------------------
// tb_team_06_clip_arbiter
// Self-checking bench for team_06_clip_arbiter: a vector table of single
// transactions, hand-written arbitration/stall/reset sequences, and a random
// phase, all watched by a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_team_06_clip_arbiter;

  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [7:0]       req_data0;
  logic [7:0]       req_data1;
  logic [1:0]       req_ready;
  logic             clip_en;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_id;
  logic             out_ready;
  logic [CNT_W-1:0] clip_count;

  int nChecks = 0;
  int nErrors = 0;

  team_06_clip_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_ready  (req_ready),
    .clip_en    (clip_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .clip_count (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator shared by the directed sequences and the reference model
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Clip transfer written straight from the rule, in plain integer math
  function automatic int clipRef(input int x);
    if (x <= 180) return x;
    if (x <= 220) return 180 + (x - 180) / 2;
    return 220;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one accepted sample at a time, tracked as a transaction.
  // Inputs only change just after a rising edge, so at the falling edge the
  // model sees exactly what the DUT will sample at the next rising edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic       id;
    logic       inc;
  } txn_t;

  txn_t       sb[$];
  logic       mPending = 1'b0;
  logic       mShown   = 1'b0;
  logic       mLast    = 1'b1;
  int         mCount   = 0;
  logic       mArmed   = 1'b0;

  always @(negedge clk) begin
    logic [1:0] expReady;
    logic       win;
    txn_t       t;
    expReady = 2'b00;
    win = 1'b0;
    if (!rst && !mPending && (req_valid != 2'b00)) begin
      if (req_valid == 2'b11) win = (mLast == 1'b0);
      else win = req_valid[1];
      expReady = win ? 2'b10 : 2'b01;
    end
    checkOutput("model.req_ready", {30'd0, req_ready}, {30'd0, expReady});
    if (mArmed) begin
      checkOutput("model.out_valid", {31'd0, out_valid}, {31'd0, mShown});
      checkOutput("model.clip_count", 32'(clip_count), 32'(mCount));
      if (mShown && sb.size() > 0) begin
        checkOutput("model.out_data", {24'd0, out_data}, {24'd0, sb[0].data});
        checkOutput("model.out_id", {31'd0, out_id}, {31'd0, sb[0].id});
      end
    end
    if (rst) begin
      mPending = 1'b0;
      mShown   = 1'b0;
      mLast    = 1'b1;
      mCount   = 0;
      sb.delete();
      mArmed   = 1'b1;
    end else if (mShown) begin
      if (out_ready) begin
        mLast = sb[0].id;
        sb.pop_front();
        mShown   = 1'b0;
        mPending = 1'b0;
      end
    end else if (mPending) begin
      mShown = 1'b1;
      if (sb.size() > 0 && sb[0].inc && mCount < CNT_MAX) mCount++;
    end else if (expReady != 2'b00) begin
      t.data = win ? req_data1 : req_data0;
      t.inc  = clip_en && (t.data > 8'd180);
      if (clip_en) t.data = 8'(clipRef(int'(t.data)));
      t.id = win;
      sb.push_back(t);
      mPending = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table: one single-requester transaction per entry
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       clipEn;
    logic       who;
    logic [7:0] data;
    logic [7:0] expData;
    logic       expInc;
  } vec_t;

  vec_t vecs[10];
  int   tbCount;

  // Runs one table entry: transfer, one PROC cycle with out_valid low, then
  // the held result, then a downstream accept
  task automatic applyStimulus(input vec_t v);
    req_valid = v.who ? 2'b10 : 2'b01;
    req_data0 = v.who ? 8'd0 : v.data;
    req_data1 = v.who ? v.data : 8'd0;
    clip_en   = v.clipEn;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("vec.grant", {30'd0, req_ready}, {30'd0, req_valid});
    tick();
    req_valid = 2'b00;
    clip_en   = ~v.clipEn;
    @(negedge clk);
    checkOutput("vec.procValid", {31'd0, out_valid}, 32'd0);
    tick();
    @(negedge clk);
    if (v.expInc && tbCount < CNT_MAX) tbCount++;
    checkOutput("vec.latency", {31'd0, out_valid}, 32'd1);
    checkOutput("vec.data", {24'd0, out_data}, {24'd0, v.expData});
    checkOutput("vec.id", {31'd0, out_id}, {31'd0, v.who});
    checkOutput("vec.count", 32'(clip_count), 32'(tbCount));
    tick();
    @(negedge clk);
    checkOutput("vec.holdValid", {31'd0, out_valid}, 32'd1);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int   got;
    logic ids[4];

    vecs[0] = '{1'b1, 1'b0, 8'd200, 8'd190, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 8'd230, 8'd220, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'd180, 8'd180, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'd250, 8'd250, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'd181, 8'd180, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 8'd220, 8'd200, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 8'd221, 8'd220, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 8'd255, 8'd220, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 8'd0,   8'd0,   1'b0};
    vecs[9] = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b0};

    rst = 1'b1; req_valid = 2'b00; req_data0 = 8'd0; req_data1 = 8'd0;
    clip_en = 1'b0; out_ready = 1'b0;

    // Reset state, with requests pending that must not be accepted
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("reset.ready", {30'd0, req_ready}, 32'd0);
    checkOutput("reset.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset.data", {24'd0, out_data}, 32'd0);
    checkOutput("reset.id", {31'd0, out_id}, 32'd0);
    checkOutput("reset.count", 32'(clip_count), 32'd0);
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
    tick();

    tbCount = 0;
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Round robin with both requesters always asking
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11; req_data0 = 8'd10; req_data1 = 8'd20;
    clip_en = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ids[got] = out_id;
        got++;
      end
      tick();
    end
    req_valid = 2'b00;
    checkOutput("rr.samples", 32'(got), 32'd4);
    if (got == 4) begin
      checkOutput("rr.id0", {31'd0, ids[0]}, 32'd0);
      checkOutput("rr.id1", {31'd0, ids[1]}, 32'd1);
      checkOutput("rr.id2", {31'd0, ids[2]}, 32'd0);
      checkOutput("rr.id3", {31'd0, ids[3]}, 32'd1);
    end
    repeat (4) tick();

    // Downstream stall in HOLD while both requesters keep asking
    req_valid = 2'b01; req_data0 = 8'd200; req_data1 = 8'd50;
    clip_en = 1'b1; out_ready = 1'b0;
    tick();
    req_valid = 2'b11;
    clip_en = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall.valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall.data", {24'd0, out_data}, 32'd190);
      checkOutput("stall.id", {31'd0, out_id}, 32'd0);
      checkOutput("stall.ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("stall.nextGrant", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;

    // Reset while a result is held: it must vanish and arbitration restarts
    req_valid = 2'b10; req_data1 = 8'd230; clip_en = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    checkOutput("rstHold.preValid", {31'd0, out_valid}, 32'd1);
    tick();
    rst = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("rstHold.ready", {30'd0, req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstHold.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstHold.count", 32'(clip_count), 32'd0);
    checkOutput("rstHold.tie", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    out_ready = 1'b1;
    repeat (4) tick();

    // Counter saturation with a narrow counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data0 = 8'd250; clip_en = 1'b1; out_ready = 1'b1;
    for (int s = 0; s < CNT_MAX + 2; s++) begin
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      tick();
    end
    @(negedge clk);
    checkOutput("sat.count", 32'(clip_count), 32'(CNT_MAX));
    tick();

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 2'($urandom_range(0, 3));
      req_data0 = $urandom_range(0, 1) ? 8'($urandom_range(170, 255)) : 8'($urandom_range(0, 255));
      req_data1 = $urandom_range(0, 1) ? 8'($urandom_range(170, 255)) : 8'($urandom_range(0, 255));
      clip_en   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    rst = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
